// File: rtl/r_nrzi_unstuff.sv
// ============================================================================
// Module   : r_nrzi_unstuff
// Brief    : Receive-path NRZI decoder and bit unstuffer. Turns the raw line
//            level stream into decoded data bits (LSB first), captures and
//            checks the PID byte and keeps per-packet length/stuff status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module r_nrzi_unstuff (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       r_bstr,
    input  logic       r_bstr_ready,
    input  logic       done,
    output logic       dec_bit,
    output logic       dec_valid,
    output logic [7:0] pid,
    output logic       pid_valid,
    output logic       pid_err,
    output logic       stuff_err,
    output logic [6:0] bit_count,
    output logic [5:0] stuffed_cnt,
    output logic       align_err,
    output logic       pkt_done
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PID      = 2'd1,
        S_BODY     = 2'd2,
        S_WAIT_EOP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        prev_level;
    logic [2:0]  ones;
    logic [6:0]  pid_sh;      // first seven PID bits, bit 0 ends up in [0]

    logic        in_idle;
    logic        in_pkt;
    logic        start;       // IDLE -> PID this cycle
    logic        active;      // a line bit is decoded this cycle
    logic        eop;         // packet closes this cycle
    logic        raw;
    logic        is_stuff;
    logic        fwd;         // decoded bit is forwarded downstream
    logic        pid_phase;
    logic        pid_last;
    logic [2:0]  ones_cur;
    logic [2:0]  ones_nxt;
    logic [6:0]  bc_cur;
    logic [6:0]  bc_nxt;
    logic [5:0]  sc_cur;
    logic [5:0]  sc_nxt;
    logic        serr_cur;
    logic [7:0]  pid_new;

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus decode/unstuff control. The bit sampled in the cycle
    // ready is first seen high is the first PID bit, so it is decoded in the
    // IDLE->PID cycle against the forced J level and with cleared counters.
    always_comb begin
        state_nxt = state;
        in_idle   = (state == S_IDLE);
        in_pkt    = (state == S_PID) || (state == S_BODY);
        start     = in_idle && r_bstr_ready;
        active    = start || (in_pkt && r_bstr_ready && !done);
        eop       = done && (in_pkt || (state == S_WAIT_EOP));
        raw       = (r_bstr == (in_idle ? 1'b0 : prev_level));
        ones_cur  = start ? 3'd0 : ones;
        bc_cur    = start ? 7'd0 : bit_count;
        sc_cur    = start ? 6'd0 : stuffed_cnt;
        serr_cur  = start ? 1'b0 : stuff_err;
        is_stuff  = (ones_cur == 3'd6);
        fwd       = active && !is_stuff;
        pid_phase = in_idle || (state == S_PID);
        pid_last  = fwd && pid_phase && (bc_cur == 7'd7);
        pid_new   = {raw, pid_sh};

        bc_nxt    = bc_cur + {6'd0, (fwd && (bc_cur != 7'd127))};
        sc_nxt    = sc_cur + {5'd0, (active && is_stuff && !raw && (sc_cur != 6'd63))};
        ones_nxt  = ones_cur;
        if (active) begin
            ones_nxt = (is_stuff || !raw) ? 3'd0 : ones_cur + 3'd1;
        end

        case (state)
            S_IDLE: begin
                if (r_bstr_ready) state_nxt = S_PID;
            end
            S_PID: begin
                if (done)               state_nxt = S_IDLE;
                else if (!r_bstr_ready) state_nxt = S_WAIT_EOP;
                else if (pid_last)      state_nxt = S_BODY;
            end
            S_BODY: begin
                if (done)               state_nxt = S_IDLE;
                else if (!r_bstr_ready) state_nxt = S_WAIT_EOP;
            end
            default: begin
                if (done) state_nxt = S_IDLE;
            end
        endcase
    end

    // Decode datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            prev_level  <= 1'b0;
            ones        <= 3'd0;
            pid_sh      <= 7'd0;
            dec_bit     <= 1'b0;
            dec_valid   <= 1'b0;
            pid         <= 8'd0;
            pid_valid   <= 1'b0;
            pid_err     <= 1'b0;
            stuff_err   <= 1'b0;
            bit_count   <= 7'd0;
            stuffed_cnt <= 6'd0;
            align_err   <= 1'b0;
            pkt_done    <= 1'b0;
        end else begin
            dec_valid   <= fwd;
            pid_valid   <= pid_last;
            pkt_done    <= eop;
            ones        <= ones_nxt;
            bit_count   <= bc_nxt;
            stuffed_cnt <= sc_nxt;
            stuff_err   <= serr_cur | (active && is_stuff && raw);

            if (active)       prev_level <= r_bstr;
            else if (in_idle) prev_level <= 1'b0;

            if (fwd) dec_bit <= raw;

            if (fwd && pid_phase) pid_sh <= {raw, pid_sh[6:1]};

            if (pid_last) begin
                pid     <= pid_new;
                pid_err <= (pid_new[7:4] != ~pid_new[3:0]);
            end

            if (start)    align_err <= 1'b0;
            else if (eop) align_err <= (bc_cur[2:0] != 3'd0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_r_nrzi_unstuff.sv
// ============================================================================
// Module   : tb_r_nrzi_unstuff
// Brief    : Self-checking bench for r_nrzi_unstuff: table of packets with
//            expected status plus a scoreboard of expected decoded bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_r_nrzi_unstuff;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       r_bstr;
    logic       r_bstr_ready;
    logic       done;
    logic       dec_bit;
    logic       dec_valid;
    logic [7:0] pid;
    logic       pid_valid;
    logic       pid_err;
    logic       stuff_err;
    logic [6:0] bit_count;
    logic [5:0] stuffed_cnt;
    logic       align_err;
    logic       pkt_done;

    r_nrzi_unstuff dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .r_bstr       (r_bstr),
        .r_bstr_ready (r_bstr_ready),
        .done         (done),
        .dec_bit      (dec_bit),
        .dec_valid    (dec_valid),
        .pid          (pid),
        .pid_valid    (pid_valid),
        .pid_err      (pid_err),
        .stuff_err    (stuff_err),
        .bit_count    (bit_count),
        .stuffed_cnt  (stuffed_cnt),
        .align_err    (align_err),
        .pkt_done     (pkt_done)
    );

    always #5 clk = ~clk;

    // Line content after SYNC: npid PID bits, tail bits, nrep x {six 1s, stuff 0}, nzero 0s
    typedef struct {
        logic [7:0]  pid_in;
        int          npid;
        logic [31:0] tail;
        int          tail_len;
        int          nrep;
        int          nzero;
        bit          exp_pv;
        logic [7:0]  exp_pid;
        bit          exp_perr;
        int          exp_bc;
        int          exp_sc;
        bit          exp_se;
        bit          exp_al;
    } vec_t;

    vec_t       vecs[8];
    int         checks = 0;
    int         errors = 0;
    logic       exp_q[$];
    int         pv_count;
    logic [7:0] pid_cap;
    logic       perr_cap;
    logic       lvl;
    int         ones_m;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer and PID capture
    always @(negedge clk) begin
        if (rst_b) begin
            if (dec_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dec_unexpected: got bit %0b, expected no bit (t=%0t)", dec_bit, $time);
                end else begin
                    check("dec_bit", int'(dec_bit), int'(exp_q.pop_front()));
                end
            end
            if (pid_valid) begin
                pv_count++;
                pid_cap  = pid;
                perr_cap = pid_err;
                check("pid_valid_with_dec_valid", int'(dec_valid), 1);
            end
        end
    end

    // One line bit: NRZI-encode and push the expected unstuffed bit
    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1;
        if (!b) lvl = ~lvl;
        r_bstr       = lvl;
        r_bstr_ready = 1'b1;
        if (ones_m == 6) begin
            ones_m = 0;
        end else begin
            exp_q.push_back(b);
            ones_m = b ? ones_m + 1 : 0;
        end
    endtask

    task automatic begin_packet();
        lvl      = 1'b0;
        ones_m   = 0;
        pv_count = 0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        begin_packet();
        for (int i = 0; i < v.npid; i++)     drive_bit(v.pid_in[i]);
        for (int i = 0; i < v.tail_len; i++) drive_bit(v.tail[i]);
        for (int r = 0; r < v.nrep; r++) begin
            for (int k = 0; k < 6; k++) drive_bit(1'b1);
            drive_bit(1'b0);
        end
        for (int i = 0; i < v.nzero; i++)    drive_bit(1'b0);
        // SE0 for two bit times, then the EOP-complete pulse
        @(posedge clk); #1; r_bstr_ready = 1'b0; r_bstr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; done = 1'b1;
        @(posedge clk); #1; done = 1'b0;
        @(negedge clk);
        check({tag, ".pkt_done"}, int'(pkt_done), 1);
        check({tag, ".bit_count"}, int'(bit_count), v.exp_bc);
        check({tag, ".stuffed_cnt"}, int'(stuffed_cnt), v.exp_sc);
        check({tag, ".stuff_err"}, int'(stuff_err), int'(v.exp_se));
        check({tag, ".align_err"}, int'(align_err), int'(v.exp_al));
        check({tag, ".pid_valid_count"}, pv_count, v.exp_pv ? 1 : 0);
        if (v.exp_pv) begin
            check({tag, ".pid"}, int'(pid_cap), int'(v.exp_pid));
            check({tag, ".pid_err"}, int'(perr_cap), int'(v.exp_perr));
        end
        check({tag, ".bits_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, ".pkt_done_pulse"}, int'(pkt_done), 0);
    endtask

    function automatic logic [39:0] all_outs();
        return {dec_bit, dec_valid, pid, pid_valid, pid_err, stuff_err,
                bit_count, stuffed_cnt, align_err, pkt_done, 12'd0};
    endfunction

    initial begin
        //            pid    npid tail      tl nrep nz  pv pid   perr bc  sc se al
        vecs[0] = '{8'hD2, 8, 32'h0,    0, 0,  0,   1, 8'hD2, 0,  8,  0, 0, 0}; // ACK
        vecs[1] = '{8'hC3, 8, 32'h1EF,  9, 0,  0,   1, 8'hC3, 0, 16,  1, 0, 0}; // DATA0 + FF
        vecs[2] = '{8'hD2, 8, 32'hFE,   8, 0,  0,   1, 8'hD2, 0, 15,  0, 1, 1}; // 7 ones
        vecs[3] = '{8'hD3, 8, 32'h0,    0, 0,  0,   1, 8'hD3, 1,  8,  0, 0, 0}; // bad PID
        vecs[4] = '{8'hD2, 8, 32'h5,    3, 0,  0,   1, 8'hD2, 0, 11,  0, 0, 1}; // 11 bits
        vecs[5] = '{8'hD2, 8, 32'h0,    0, 0, 122,  1, 8'hD2, 0, 127, 0, 0, 1}; // 130 bits
        vecs[6] = '{8'hD2, 8, 32'h0,    1, 64, 0,   1, 8'hD2, 0, 127, 63, 0, 1}; // stuff sat
        vecs[7] = '{8'h02, 3, 32'h0,    0, 0,  0,   0, 8'h00, 0,  3,  0, 0, 1}; // short

        rst_b = 1'b0; r_bstr = 1'b0; r_bstr_ready = 1'b0; done = 1'b0;
        pv_count = 0; pid_cap = 8'd0; perr_cap = 1'b0; lvl = 1'b0; ones_m = 0;
        #12;
        check("reset_outputs", int'(all_outs() != 40'd0), 0);
        @(negedge clk); #2 rst_b = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (2) @(posedge clk);
        end

        // Reset in the middle of a packet body
        begin_packet();
        for (int i = 0; i < 8; i++) drive_bit(vecs[0].pid_in[i]);
        for (int i = 0; i < 6; i++) drive_bit(1'b0);
        @(posedge clk); #3;
        rst_b = 1'b0; r_bstr_ready = 1'b0; r_bstr = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_outputs_async", int'(all_outs() != 40'd0), 0);
        @(negedge clk);
        check("midreset_outputs_held", int'(all_outs() != 40'd0), 0);
        #2 rst_b = 1'b1;
        @(posedge clk); #1; done = 1'b1;
        @(posedge clk); #1; done = 1'b0;
        @(negedge clk);
        check("stale_done_ignored", int'(pkt_done), 0);
        repeat (2) @(posedge clk);
        run_vec(vecs[0], "post_reset_ack");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
